// File: rtl/tlb_op_ctrl_pkg.sv
// Shared types for the CP0 TLB op controller: op encodings, TLB entry layout,
// controller states and the probe-miss Index value.
package tlb_op_ctrl_pkg;

    typedef enum logic [2:0] {
        TU_NONE  = 3'd0,
        TU_TLBP  = 3'd1,
        TU_TLBR  = 3'd2,
        TU_TLBWI = 3'd3,
        TU_TLBWR = 3'd4
    } tu_op_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WRITE = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RESP  = 3'd4
    } ctrl_state_t;

    localparam logic [31:0] TLB_PROBE_MISS = 32'h8000_0000;

    // Encodings outside TLBP..TLBWR behave like NONE.
    function automatic logic is_tlb_op(input logic [2:0] op);
        return (op >= 3'(TU_TLBP)) && (op <= 3'(TU_TLBWR));
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Pipeline <-> TLB op controller bus: request handshake, CP0 operands, completion.
//  master: pipeline side (drives request), slave: controller side (drives response).
interface tlb_op_ctrl_if
    import tlb_op_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 4
);
    logic             req_valid;
    logic [2:0]       req_op;
    logic             req_ready;
    logic [IDX_W-1:0] cp0_index;
    logic [31:0]      cp0_entryhi;
    logic [31:0]      cp0_entrylo0;
    logic [31:0]      cp0_entrylo1;
    logic             resp_valid;
    logic [2:0]       resp_op;
    logic [31:0]      resp_index;
    tlb_entry_t       resp_entry;

    modport master (
        output req_valid, req_op, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
        input  req_ready, resp_valid, resp_op, resp_index, resp_entry
    );

    modport slave (
        input  req_valid, req_op, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
        output req_ready, resp_valid, resp_op, resp_index, resp_entry
    );
endinterface

// File: rtl/tlb_random_ctr.sv
// CP0 Random counter: counts down from TLB_ENTRIES-1 to cp0_wired, then wraps.
//  clk, resetn         clock, async active-low reset (Random -> TLB_ENTRIES-1)
//  cp0_wired, wired_we CP0 Wired value and its write strobe
//  random_o            current Random value
module tlb_random_ctr #(
    parameter  int unsigned TLB_ENTRIES = 16,
    localparam int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random_o
);
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    // A Wired write restarts the count; '<=' also recovers if Wired moved above Random.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_o <= RAND_TOP;
        end else if (wired_we || (cp0_wired >= RAND_TOP) || (random_o <= cp0_wired)) begin
            random_o <= RAND_TOP;
        end else begin
            random_o <= random_o - IDX_W'(1);
        end
    end
endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the shared TLB array and returns CP0 results.
//  bus          pipeline request/response (slave side)
//  cp0_wired, wired_we, random_o   Wired input and Random output
//  tlb_key/tlb_ridx -> array probe/read; tlb_rdata/tlb_phit/tlb_pidx <- array (1-cycle)
//  tlb_we/tlb_widx/tlb_wdata -> array write; tu_flush -> translation unit
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter  int unsigned TLB_ENTRIES = 16,
    localparam int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             resetn,
    tlb_op_ctrl_if.slave     bus,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random_o,
    output logic [31:0]      tlb_key,
    output logic [IDX_W-1:0] tlb_ridx,
    input  tlb_entry_t       tlb_rdata,
    input  logic             tlb_phit,
    input  logic [IDX_W-1:0] tlb_pidx,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_widx,
    output tlb_entry_t       tlb_wdata,
    output logic             tu_flush
);
    ctrl_state_t state;
    tu_op_t      op_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic [2:0]  resp_op_q;
    logic [31:0] index_q;
    tlb_entry_t  entry_q;
    logic [31:0] probe_index_c;
    logic        accept_c;

    tlb_random_ctr #(.TLB_ENTRIES(TLB_ENTRIES)) u_random (
        .clk       (clk),
        .resetn    (resetn),
        .cp0_wired (cp0_wired),
        .wired_we  (wired_we),
        .random_o  (random_o)
    );

    assign accept_c      = (state == ST_IDLE) && bus.req_valid && is_tlb_op(bus.req_op);
    assign probe_index_c = tlb_phit ? 32'(tlb_pidx) : TLB_PROBE_MISS;

    // Array outputs are already registered; during RESP they are passed straight through so
    // the result is valid alongside resp_valid, then held in index_q/entry_q until next RESP.
    assign bus.resp_index = ((state == ST_RESP) && (op_q == TU_TLBP)) ? probe_index_c : index_q;
    assign bus.resp_entry = ((state == ST_RESP) && (op_q == TU_TLBR)) ? tlb_rdata : entry_q;
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_op    = resp_op_q;

    // Control FSM with registered array strobes; strobes default low and last one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            op_q         <= TU_NONE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_op_q    <= 3'd0;
            index_q      <= 32'd0;
            entry_q      <= '0;
            tlb_key      <= 32'd0;
            tlb_ridx     <= '0;
            tlb_we       <= 1'b0;
            tlb_widx     <= '0;
            tlb_wdata    <= '0;
            tu_flush     <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            tlb_key      <= 32'd0;
            tlb_ridx     <= '0;
            tlb_we       <= 1'b0;
            tlb_widx     <= '0;
            tlb_wdata    <= '0;
            tu_flush     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_q    <= tu_op_t'(bus.req_op);
                        ready_q <= 1'b0;
                        case (tu_op_t'(bus.req_op))
                            TU_TLBP: begin
                                tlb_key <= bus.cp0_entryhi;
                                state   <= ST_ISSUE;
                            end
                            TU_TLBR: begin
                                tlb_ridx <= bus.cp0_index;
                                state    <= ST_ISSUE;
                            end
                            default: begin
                                // TLBWR targets Random as seen in the accept cycle.
                                tlb_we    <= 1'b1;
                                tlb_widx  <= (tu_op_t'(bus.req_op) == TU_TLBWR) ? random_o
                                                                                 : bus.cp0_index;
                                tlb_wdata <= '{hi: bus.cp0_entryhi, lo0: bus.cp0_entrylo0,
                                               lo1: bus.cp0_entrylo1};
                                state     <= ST_WRITE;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    resp_valid_q <= 1'b1;
                    resp_op_q    <= 3'(op_q);
                    state        <= ST_RESP;
                end
                ST_WRITE: begin
                    tu_flush <= 1'b1;
                    state    <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    resp_valid_q <= 1'b1;
                    resp_op_q    <= 3'(op_q);
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (op_q == TU_TLBP) index_q <= probe_index_c;
                    if (op_q == TU_TLBR) entry_q <= tlb_rdata;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural 16-entry TLB array (registered outputs).
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    localparam logic [31:0] E_HI  = 32'h0040_2003;
    localparam logic [31:0] E_LO0 = 32'h0001_2017;
    localparam logic [31:0] E_LO1 = 32'h0001_3017;
    localparam logic [31:0] W_HI  = 32'h0123_4005;
    localparam logic [31:0] W_LO0 = 32'h0004_5007;
    localparam logic [31:0] W_LO1 = 32'h0004_6007;

    logic          clk;
    logic          resetn;
    logic [IW-1:0] cp0_wired;
    logic          wired_we;
    logic [IW-1:0] random_o;
    logic [31:0]   tlb_key;
    logic [IW-1:0] tlb_ridx;
    tlb_entry_t    tlb_rdata;
    logic          tlb_phit;
    logic [IW-1:0] tlb_pidx;
    logic          tlb_we;
    logic [IW-1:0] tlb_widx;
    tlb_entry_t    tlb_wdata;
    logic          tu_flush;

    tlb_entry_t    mem [N];
    int            n_cmp;
    int            n_bad;

    tlb_op_ctrl_if #(.IDX_W(IW)) bus ();

    tlb_op_ctrl #(.TLB_ENTRIES(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .cp0_wired (cp0_wired),
        .wired_we  (wired_we),
        .random_o  (random_o),
        .tlb_key   (tlb_key),
        .tlb_ridx  (tlb_ridx),
        .tlb_rdata (tlb_rdata),
        .tlb_phit  (tlb_phit),
        .tlb_pidx  (tlb_pidx),
        .tlb_we    (tlb_we),
        .tlb_widx  (tlb_widx),
        .tlb_wdata (tlb_wdata),
        .tu_flush  (tu_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < int'(N); i++) mem[i] = '0;
        tlb_rdata = '0;
        tlb_phit  = 1'b0;
        tlb_pidx  = '0;
    end

    // TLB array: write, registered read and registered probe (match VPN2 and ASID).
    always @(posedge clk) begin
        logic          hit;
        logic [IW-1:0] hidx;
        hit  = 1'b0;
        hidx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (mem[i].hi[31:13] == tlb_key[31:13] && mem[i].hi[7:0] == tlb_key[7:0]) begin
                hit  = 1'b1;
                hidx = IW'(i);
            end
        end
        if (tlb_we) mem[tlb_widx] <= tlb_wdata;
        tlb_rdata <= mem[tlb_ridx];
        tlb_phit  <= hit;
        tlb_pidx  <= hidx;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [IW-1:0] idx,
                         input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.cp0_index    = idx;
        bus.cp0_entryhi  = hi;
        bus.cp0_entrylo0 = lo0;
        bus.cp0_entrylo1 = lo1;
    endtask

    task automatic scramble();
        bus.req_valid    = 1'b0;
        bus.req_op       = 3'd0;
        bus.cp0_index    = 4'hA;
        bus.cp0_entryhi  = 32'hFFFF_FFFF;
        bus.cp0_entrylo0 = 32'hDEAD_BEEF;
        bus.cp0_entrylo1 = 32'hCAFE_F00D;
    endtask

    initial begin
        int n;
        int we_cnt;
        int resp_cnt;
        logic [IW-1:0] e;
        n_cmp = 0;
        n_bad = 0;
        resetn    = 1'b0;
        cp0_wired = '0;
        wired_we  = 1'b0;
        scramble();

        // reset state
        tick();
        chk("rst_ready", 128'(bus.req_ready), 128'(1));
        chk("rst_random", 128'(random_o), 128'(15));
        chk("rst_we", 128'(tlb_we), 128'(0));
        chk("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
        chk("rst_flush", 128'(tu_flush), 128'(0));
        chk("rst_resp_index", 128'(bus.resp_index), 128'(0));
        resetn = 1'b1;
        tick();

        // TLBWI index 5
        drive(3'd3, 4'd5, E_HI, E_LO0, E_LO1);
        tick();
        chk("wi_we", 128'(tlb_we), 128'(1));
        chk("wi_widx", 128'(tlb_widx), 128'(5));
        chk("wi_wdata", 128'(tlb_wdata), 128'({E_HI, E_LO0, E_LO1}));
        chk("wi_ready_busy", 128'(bus.req_ready), 128'(0));
        chk("wi_no_flush_yet", 128'(tu_flush), 128'(0));
        scramble();
        tick();
        chk("wi_we_pulse", 128'(tlb_we), 128'(0));
        chk("wi_flush", 128'(tu_flush), 128'(1));
        chk("wi_no_resp_yet", 128'(bus.resp_valid), 128'(0));
        tick();
        chk("wi_resp_valid", 128'(bus.resp_valid), 128'(1));
        chk("wi_resp_op", 128'(bus.resp_op), 128'(3));
        chk("wi_flush_pulse", 128'(tu_flush), 128'(0));
        tick();
        chk("wi_resp_pulse", 128'(bus.resp_valid), 128'(0));
        chk("wi_ready_back", 128'(bus.req_ready), 128'(1));

        // TLBP hit
        drive(3'd1, 4'd0, E_HI, 32'd0, 32'd0);
        tick();
        chk("p_key", 128'(tlb_key), 128'(E_HI));
        chk("p_no_resp_yet", 128'(bus.resp_valid), 128'(0));
        scramble();
        tick();
        chk("p_resp_valid", 128'(bus.resp_valid), 128'(1));
        chk("p_hit_index", 128'(bus.resp_index), 128'(5));
        tick();
        chk("p_hit_index_held", 128'(bus.resp_index), 128'(5));
        chk("p_key_pulse", 128'(tlb_key), 128'(0));

        // TLBP miss
        drive(3'd1, 4'd0, 32'h0080_0003, 32'd0, 32'd0);
        tick();
        scramble();
        tick();
        chk("pm_resp_valid", 128'(bus.resp_valid), 128'(1));
        chk("pm_index", 128'(bus.resp_index), 128'(32'h8000_0000));
        tick();

        // TLBR index 5
        drive(3'd2, 4'd5, 32'd0, 32'd0, 32'd0);
        tick();
        chk("r_ridx", 128'(tlb_ridx), 128'(5));
        chk("r_no_resp_yet", 128'(bus.resp_valid), 128'(0));
        scramble();
        tick();
        chk("r_resp_valid", 128'(bus.resp_valid), 128'(1));
        chk("r_resp_op", 128'(bus.resp_op), 128'(2));
        chk("r_entry", 128'(bus.resp_entry), 128'({E_HI, E_LO0, E_LO1}));
        tick();
        chk("r_entry_held", 128'(bus.resp_entry), 128'({E_HI, E_LO0, E_LO1}));

        // NONE and illegal encodings are ignored
        drive(3'd0, 4'd5, E_HI, 32'd0, 32'd0);
        tick();
        chk("none_ready", 128'(bus.req_ready), 128'(1));
        chk("none_we", 128'(tlb_we), 128'(0));
        bus.req_op = 3'd7;
        tick();
        chk("ill_ready", 128'(bus.req_ready), 128'(1));
        chk("ill_we", 128'(tlb_we), 128'(0));
        tick();
        chk("ill_resp", 128'(bus.resp_valid), 128'(0));
        scramble();

        // TLBWR accepted at Random=9 with a simultaneous Wired write; req_valid held while busy
        n = 0;
        while (random_o != 4'd9 && n < 40) begin
            tick();
            n++;
        end
        chk("wr_random_reach9", 128'(random_o), 128'(9));
        drive(3'd4, 4'd2, W_HI, W_LO0, W_LO1);
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        chk("wr_we", 128'(tlb_we), 128'(1));
        chk("wr_widx", 128'(tlb_widx), 128'(9));
        chk("wr_wdata", 128'(tlb_wdata), 128'({W_HI, W_LO0, W_LO1}));
        chk("wr_random_forced", 128'(random_o), 128'(15));
        we_cnt   = 1;
        resp_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (tlb_we) we_cnt++;
            if (bus.resp_valid) begin
                resp_cnt++;
                bus.req_valid = 1'b0;
            end
        end
        chk("wr_single_write", 128'(we_cnt), 128'(1));
        chk("wr_single_resp", 128'(resp_cnt), 128'(1));

        // Random with Wired=4
        cp0_wired = 4'd4;
        wired_we  = 1'b1;
        tick();
        wired_we = 1'b0;
        chk("rnd_wired_we", 128'(random_o), 128'(15));
        e = 4'd15;
        for (int s = 0; s < 14; s++) begin
            e = (e == 4'd4) ? 4'd15 : e - 4'd1;
            tick();
            chk("rnd_seq", 128'(random_o), 128'(e));
        end
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        chk("rnd_we_mid", 128'(random_o), 128'(15));
        tick();
        chk("rnd_after_we", 128'(random_o), 128'(14));
        cp0_wired = 4'd15;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("rnd_hold15", 128'(random_o), 128'(15));
        end
        cp0_wired = 4'd0;

        // async reset in the middle of a write
        drive(3'd3, 4'd3, E_HI, E_LO0, E_LO1);
        tick();
        chk("mr_we_before", 128'(tlb_we), 128'(1));
        scramble();
        resetn = 1'b0;
        #1;
        chk("mr_we", 128'(tlb_we), 128'(0));
        chk("mr_ready", 128'(bus.req_ready), 128'(1));
        chk("mr_random", 128'(random_o), 128'(15));
        chk("mr_widx", 128'(tlb_widx), 128'(0));
        tick();
        resetn = 1'b1;
        tick();
        chk("mr_no_flush", 128'(tu_flush), 128'(0));
        chk("mr_no_resp", 128'(bus.resp_valid), 128'(0));
        chk("mr_idle_ready", 128'(bus.req_ready), 128'(1));
        chk("mr_no_array_write", 128'(mem[3]), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
